// File: rtl/bus_pkg.sv
// Shared types and constants for the bus requester: FSM encoding, default
// bus widths and the wr_ni operation encoding.
package bus_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    localparam logic OP_RD = 1'b1;
    localparam logic OP_WR = 1'b0;
endpackage

// File: rtl/bus_requester_if.sv
// Command, bus and response signals of the requester; master is the
// requester's view, slave the view of whatever surrounds it.
interface bus_requester_if
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_wr_ni;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  rq;
    logic [ADDR_WIDTH-1:0] address;
    logic                  wr_ni;
    logic [DATA_WIDTH-1:0] dataW;
    logic                  ack;
    logic [DATA_WIDTH-1:0] dataR;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_timeout;
    logic                  busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wr_ni, cmd_data, ack, dataR,
        output cmd_ready, rq, address, wr_ni, dataW,
               rsp_valid, rsp_data, rsp_timeout, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wr_ni, cmd_data, ack, dataR,
        input  cmd_ready, rq, address, wr_ni, dataW,
               rsp_valid, rsp_data, rsp_timeout, busy
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; pushes while full and pops while
// empty are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    // Same index with opposite wrap bits means the writer lapped the reader.
    assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/bus_requester.sv
// Buffers local commands and issues them one at a time on a rq/ack bus,
// aborting any transaction that waits TIMEOUT cycles without an ack.
module bus_requester
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic            clk,
    input  logic            reset,
    bus_requester_if.master bus
);
    localparam int CMD_W = ADDR_WIDTH + 1 + DATA_WIDTH;
    localparam int CW    = $clog2(TIMEOUT + 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [CMD_W-1:0]      fifo_dout;
    logic                  fifo_full, fifo_empty, pop;
    logic                  rq_r, wr_ni_r, rsp_valid_r, rsp_timeout_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] dataw_r, rsp_data_r;

    assign pop = (state == IDLE) && !fifo_empty;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.cmd_valid),
        .pop   (pop),
        .din   ({bus.cmd_addr, bus.cmd_wr_ni, bus.cmd_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            rq_r          <= 1'b0;
            addr_r        <= '0;
            wr_ni_r       <= 1'b0;
            dataw_r       <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= '0;
            rsp_timeout_r <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state)
                IDLE: if (!fifo_empty) begin
                    {addr_r, wr_ni_r, dataw_r} <= fifo_dout;
                    rq_r  <= 1'b1;
                    cnt   <= '0;
                    state <= REQ;
                end
                REQ: begin
                    cnt <= cnt + CW'(1);
                    // An ack on the final counted cycle still completes normally.
                    if (bus.ack) begin
                        rq_r          <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_timeout_r <= 1'b0;
                        rsp_data_r    <= (wr_ni_r == OP_RD) ? bus.dataR : '0;
                        state         <= GAP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rq_r          <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                        rsp_data_r    <= '0;
                        state         <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = !fifo_full;
    assign bus.busy        = (state != IDLE) || !fifo_empty;
    assign bus.rq          = rq_r;
    assign bus.address     = addr_r;
    assign bus.wr_ni       = wr_ni_r;
    assign bus.dataW       = dataw_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_data    = rsp_data_r;
    assign bus.rsp_timeout = rsp_timeout_r;
endmodule

// File: tb/tb_bus_requester.sv
// Scoreboard bench for bus_requester: a negedge monitor/responder pops the
// expected transactions and responses queued by the stimulus tasks.
module tb_bus_requester;
    import bus_pkg::*;

    localparam int DW = 8, AW = 4, DEPTH = 4, TO = 15;

    typedef struct {
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
        logic [DW-1:0] rd;
    } txn_t;

    typedef struct {
        logic          to;
        logic [DW-1:0] d;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bus_requester_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bus_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    txn_t txn_q[$];
    rsp_t rsp_q[$];
    txn_t cur;
    rsp_t er;
    int   tests = 0, fails = 0, rsp_cnt = 0, ack_k = 0;
    int   low_cnt = 2, cyc = 0;
    bit   stray = 0, rq_prev = 0, rsp_prev = 0;

    // Monitor first, then responder: ack is raised for the ack_k-th REQ edge.
    always @(negedge clk) begin
        if (!reset) begin
            rq_prev = 0; rsp_prev = 0; low_cnt = 2; cyc = 0;
            bus.ack = 1'b0; bus.dataR = '0;
        end else begin
            if (bus.rq && !rq_prev) begin
                tests++;
                if (low_cnt < 2) begin
                    fails++; $display("FAIL rq_gap: rq low %0d cycles, want >= 2", low_cnt);
                end
                tests++;
                if (txn_q.size() == 0) begin
                    fails++; $display("FAIL txn_unexpected: addr %0h wr_ni %0b", bus.address, bus.wr_ni);
                end else begin
                    cur = txn_q.pop_front();
                    if ({bus.address, bus.wr_ni, bus.dataW} !== {cur.a, cur.w, cur.d}) begin
                        fails++;
                        $display("FAIL txn_order: got %0h/%0b/%0h want %0h/%0b/%0h",
                                 bus.address, bus.wr_ni, bus.dataW, cur.a, cur.w, cur.d);
                    end
                end
            end else if (bus.rq) begin
                tests++;
                if ({bus.address, bus.wr_ni, bus.dataW} !== {cur.a, cur.w, cur.d}) begin
                    fails++;
                    $display("FAIL bus_stable: got %0h/%0b/%0h want %0h/%0b/%0h",
                             bus.address, bus.wr_ni, bus.dataW, cur.a, cur.w, cur.d);
                end
            end
            if (!bus.rq) low_cnt++; else low_cnt = 0;

            if (bus.rsp_valid) begin
                rsp_cnt++;
                tests++;
                if (rsp_prev) begin
                    fails++; $display("FAIL rsp_pulse: rsp_valid high 2 cycles, want 1");
                end
                tests++;
                if (rsp_q.size() == 0) begin
                    fails++; $display("FAIL rsp_unexpected: data %0h timeout %0b", bus.rsp_data, bus.rsp_timeout);
                end else begin
                    er = rsp_q.pop_front();
                    if ({bus.rsp_timeout, bus.rsp_data} !== {er.to, er.d}) begin
                        fails++;
                        $display("FAIL rsp_value: got to=%0b data=%0h want to=%0b data=%0h",
                                 bus.rsp_timeout, bus.rsp_data, er.to, er.d);
                    end
                end
            end
            rsp_prev = bus.rsp_valid;
            rq_prev  = bus.rq;

            if (bus.rq) begin
                cyc++;
                bus.ack = (ack_k != 0) && (cyc == ack_k);
            end else begin
                cyc = 0;
                bus.ack = stray;
            end
            bus.dataR = bus.ack ? (bus.rq ? cur.rd : 8'hFF) : 8'($urandom);
        end
    end

    task automatic push(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                        input logic [DW-1:0] rd, output bit acc);
        txn_t t;
        rsp_t r;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_wr_ni = w; bus.cmd_data = d;
        acc = bus.cmd_ready;
        if (acc) begin
            t.a = a; t.w = w; t.d = d; t.rd = rd;
            txn_q.push_back(t);
            r.to = (ack_k == 0) || (ack_k > TO);
            r.d  = (r.to || w == OP_WR) ? 8'h00 : rd;
            rsp_q.push_back(r);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rq();
        int g = 0;
        while (!bus.rq && g < 20) begin @(negedge clk); g++; end
        tests++;
        if (bus.rq !== 1'b1) begin fails++; $display("FAIL wait_rq: rq %0b after %0d cycles, want 1", bus.rq, g); end
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((bus.busy || bus.rq) && g < 300) begin @(negedge clk); g++; end
        repeat (2) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle: busy %0b want 0", bus.busy); end
        tests++;
        if (txn_q.size() != 0 || rsp_q.size() != 0) begin
            fails++; $display("FAIL sb_drain: %0d txn / %0d rsp outstanding, want 0", txn_q.size(), rsp_q.size());
        end
    endtask

    // Counts negedges with rq high for the transaction just pushed.
    task automatic count_rq(output int n);
        int g = 0;
        n = 0;
        while (!bus.rq && g < 10) begin @(negedge clk); g++; end
        while (bus.rq && n < 40) begin n++; @(negedge clk); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.rq, bus.address, bus.wr_ni, bus.dataW} !== '0) begin
            fails++; $display("FAIL reset_bus: rq/addr/wr/dataW %0b/%0h/%0b/%0h want 0", bus.rq, bus.address, bus.wr_ni, bus.dataW);
        end
        tests++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_timeout} !== '0) begin
            fails++; $display("FAIL reset_rsp: %0b/%0h/%0b want 0", bus.rsp_valid, bus.rsp_data, bus.rsp_timeout);
        end
        tests++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL reset_flags: busy %0b ready %0b want 0/1", bus.busy, bus.cmd_ready);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.rq !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL post_reset: rq %0b busy %0b want 0/0", bus.rq, bus.busy);
        end
    endtask

    task automatic test_read();
        bit acc;
        int n = 0;
        ack_k = 2;
        push(4'h3, OP_RD, 8'h00, 8'hA5, acc);
        tests++; if (acc !== 1'b1) begin fails++; $display("FAIL rd_accept: %0b want 1", acc); end
        tests++; if (bus.rq !== 1'b0) begin fails++; $display("FAIL rd_rq_early: %0b want 0", bus.rq); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rd_busy: %0b want 1", bus.busy); end
        @(posedge clk); #1;
        tests++; if (bus.rq !== 1'b1) begin fails++; $display("FAIL rd_latency: rq %0b want 1", bus.rq); end
        while (!bus.rsp_valid && n < 40) begin @(negedge clk); n++; end
        tests++; if (n != 3) begin fails++; $display("FAIL rd_rsp_time: %0d cycles want 3", n); end
        tests++; if (bus.rsp_data !== 8'hA5) begin fails++; $display("FAIL rd_data: %0h want a5", bus.rsp_data); end
        tests++; if (bus.rsp_timeout !== 1'b0) begin fails++; $display("FAIL rd_to: %0b want 0", bus.rsp_timeout); end
        @(negedge clk);
        tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_pulse: %0b want 0", bus.rsp_valid); end
        tests++; if (bus.rsp_data !== 8'hA5) begin fails++; $display("FAIL rd_hold: %0h want a5", bus.rsp_data); end
        wait_idle();
    endtask

    task automatic test_write();
        bit acc;
        int n = 0;
        ack_k = 3;
        push(4'h9, OP_WR, 8'h5C, 8'hEE, acc);
        @(posedge clk); #1;
        tests++;
        if ({bus.rq, bus.address, bus.wr_ni, bus.dataW} !== {1'b1, 4'h9, 1'b0, 8'h5C}) begin
            fails++; $display("FAIL wr_bus: %0b/%0h/%0b/%0h want 1/9/0/5c", bus.rq, bus.address, bus.wr_ni, bus.dataW);
        end
        while (!bus.rsp_valid && n < 40) begin @(negedge clk); n++; end
        tests++; if (n != 4) begin fails++; $display("FAIL wr_rsp_time: %0d cycles want 4", n); end
        tests++; if (bus.rsp_data !== 8'h00) begin fails++; $display("FAIL wr_data: %0h want 0", bus.rsp_data); end
        tests++; if (bus.rsp_timeout !== 1'b0) begin fails++; $display("FAIL wr_to: %0b want 0", bus.rsp_timeout); end
        wait_idle();
    endtask

    task automatic test_timeout();
        bit acc;
        int n, rc;
        ack_k = 0;
        push(4'h2, OP_RD, 8'h00, 8'h11, acc);
        count_rq(n);
        tests++; if (n != TO) begin fails++; $display("FAIL to_len: rq high %0d cycles want %0d", n, TO); end
        tests++;
        if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_data} !== {1'b1, 1'b1, 8'h00}) begin
            fails++; $display("FAIL to_rsp: v/to/data %0b/%0b/%0h want 1/1/0", bus.rsp_valid, bus.rsp_timeout, bus.rsp_data);
        end
        stray = 1;
        @(negedge clk);
        rc = rsp_cnt;
        repeat (3) @(negedge clk);
        stray = 0;
        @(negedge clk);
        tests++; if (rsp_cnt != rc) begin fails++; $display("FAIL late_ack: %0d extra rsp want 0", rsp_cnt - rc); end
        tests++;
        if ({bus.rq, bus.rsp_timeout, bus.rsp_data} !== {1'b0, 1'b1, 8'h00}) begin
            fails++; $display("FAIL late_ack_hold: rq/to/data %0b/%0b/%0h want 0/1/0", bus.rq, bus.rsp_timeout, bus.rsp_data);
        end
        wait_idle();
    endtask

    task automatic test_collision();
        bit acc;
        int n;
        ack_k = TO;
        push(4'hE, OP_RD, 8'h00, 8'h3C, acc);
        count_rq(n);
        tests++; if (n != TO) begin fails++; $display("FAIL col_len: rq high %0d cycles want %0d", n, TO); end
        tests++;
        if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_data} !== {1'b1, 1'b0, 8'h3C}) begin
            fails++; $display("FAIL col_rsp: v/to/data %0b/%0b/%0h want 1/0/3c", bus.rsp_valid, bus.rsp_timeout, bus.rsp_data);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        bit acc;
        bit prev = 1;
        int g = 0;
        logic [AW-1:0] a;
        ack_k = 0;
        push(4'h1, OP_RD, 8'h00, 8'h00, acc);
        wait_rq();
        for (int i = 0; i < DEPTH; i++) begin
            a = AW'(i + 2);
            push(a, logic'(i[0]), 8'(8'h20 + i), 8'h00, acc);
            tests++; if (acc !== 1'b1) begin fails++; $display("FAIL b2b_accept%0d: %0b want 1", i, acc); end
        end
        tests++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL b2b_full: ready %0b want 0", bus.cmd_ready); end
        // Hold a rejected command through the pop edge that frees a slot.
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_addr = 4'h6; bus.cmd_wr_ni = OP_WR; bus.cmd_data = 8'h66;
        tests++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL b2b_reject: ready %0b want 0", bus.cmd_ready); end
        while (g < 60) begin
            @(negedge clk); g++;
            if (bus.rq && !prev) break;
            prev = bus.rq;
        end
        tests++;
        if (bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_pop_push: ready %0b after pop want 1 (cycles %0d)", bus.cmd_ready, g);
        end
        bus.cmd_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        bit acc;
        int rc;
        ack_k = 0;
        push(4'h7, OP_RD, 8'h00, 8'h00, acc);
        wait_rq();
        push(4'h4, OP_WR, 8'h77, 8'h00, acc);
        push(4'h5, OP_RD, 8'h00, 8'h00, acc);
        @(negedge clk);
        rc = rsp_cnt;
        #2 reset = 1'b0;
        #1;
        tests++; if (bus.rq !== 1'b0) begin fails++; $display("FAIL rst_rq: %0b want 0", bus.rq); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: %0b want 0", bus.busy); end
        tests++;
        if ({bus.address, bus.rsp_valid, bus.cmd_ready} !== {4'h0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL rst_async: addr/v/ready %0h/%0b/%0b want 0/0/1", bus.address, bus.rsp_valid, bus.cmd_ready);
        end
        txn_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        tests++; if (rsp_cnt != rc) begin fails++; $display("FAIL rst_no_rsp: %0d rsp want 0", rsp_cnt - rc); end
        tests++;
        if ({bus.rq, bus.busy, bus.cmd_ready} !== {1'b0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL rst_release: rq/busy/ready %0b/%0b/%0b want 0/0/1", bus.rq, bus.busy, bus.cmd_ready);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_wr_ni = 1'b0; bus.cmd_data = '0;
        bus.ack = 1'b0; bus.dataR = '0;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/bus_requester.md
BUS_REQUESTER -- requirements
Module: bus_requester

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bus width SHALL be this many bits.
REQ-002 Parameter ADDR_WIDTH, default 4, address bus width SHALL be this many bits.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of 2), command buffer depth SHALL be this many entries.
REQ-004 Parameter TIMEOUT, default 15, max REQ-state cycles without ack SHALL be this value.
REQ-005 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 cmd_valid  input  1  local command offered.
REQ-008 cmd_ready  output  1  buffer can accept; SHALL equal !fifo_full.
REQ-009 cmd_addr  input  ADDR_WIDTH  command address.
REQ-010 cmd_wr_ni  input  1  1 = read, 0 = write.
REQ-011 cmd_data  input  DATA_WIDTH  write data.
REQ-012 rq  output  1  bus request to the responder.
REQ-013 address  output  ADDR_WIDTH  bus address.
REQ-014 wr_ni  output  1  bus operation, 1 = read, 0 = write.
REQ-015 dataW  output  DATA_WIDTH  bus write data.
REQ-016 ack  input  1  responder acknowledge, one-cycle pulse.
REQ-017 dataR  input  DATA_WIDTH  responder read data, valid when ack = 1.
REQ-018 rsp_valid  output  1  one-cycle completion pulse.
REQ-019 rsp_data  output  DATA_WIDTH  captured read data; 0 for writes and timeouts.
REQ-020 rsp_timeout  output  1  qualifies rsp_valid: 1 = transaction aborted.
REQ-021 busy  output  1  high when state != IDLE or FIFO non-empty.

Function
REQ-022 The command handshake SHALL complete on any rising edge with cmd_valid & cmd_ready, pushing {addr, wr_ni, data} into the FIFO.
REQ-023 The FSM SHALL have states IDLE, REQ, GAP.
REQ-024 In IDLE with a non-empty FIFO, one edge SHALL pop the head, register address/wr_ni/dataW, set rq = 1, clear the timeout counter and enter REQ.
REQ-025 rq SHALL rise on the first edge after the push edge when IDLE and the FIFO is empty (1-cycle latency).
REQ-026 address, wr_ni and dataW SHALL be stable for the entire time rq = 1.
REQ-027 In REQ with ack = 1, the FSM SHALL clear rq, pulse rsp_valid, set rsp_timeout = 0, load rsp_data = dataR for reads (0 for writes) and enter GAP on one edge.
REQ-028 In REQ with ack = 0, the counter SHALL increment; on reaching TIMEOUT, the FSM SHALL clear rq, pulse rsp_valid with rsp_timeout = 1 and rsp_data = 0, and enter GAP.
REQ-029 If ack = 1 on the edge at which the counter reaches TIMEOUT, ack SHALL take priority (normal completion).
REQ-030 GAP SHALL last exactly one cycle with rq = 0, then enter IDLE, so rq always has a low phase (≥2 cycles) between transactions.
REQ-031 ack SHALL be ignored in IDLE and GAP.
REQ-032 rsp_valid SHALL be high for exactly one cycle per transaction; rsp_data and rsp_timeout SHALL hold until the next rsp_valid.
REQ-033 When the FIFO is full, cmd_ready SHALL be 0 and pushes SHALL be ignored; a pop on that edge does not enable a same-edge push.
REQ-034 FIFO pointers SHALL be log2(FIFO_DEPTH) bits wide with an extra wrap bit; full/empty SHALL be derived from the pointers, and wrap-around SHALL preserve order.

Reset
REQ-035 While reset = 0, immediately and asynchronously: state = IDLE, FIFO empty, counter = 0, rq = 0, address = 0, wr_ni = 0, dataW = 0, rsp_valid = 0, rsp_data = 0, rsp_timeout = 0.
REQ-036 Reset asserted mid-transaction SHALL drop rq at once and discard all buffered commands, with no rsp_valid generated for them.

Structure
REQ-037 Package bus_pkg SHALL hold the FSM state encoding, the default DATA_WIDTH/ADDR_WIDTH, and the rd/wr encoding constants of wr_ni.
REQ-038 The command buffer SHALL be a sub-module sync_fifo (parameterized width/depth, push/pop/full/empty).

Verification
REQ-039 Read: push addr 0x3 rd; responder acks in cycle 2 with dataR 0xA5 -> rq high 1 cycle after push, rsp_valid pulse with rsp_data 0xA5, rsp_timeout 0.
REQ-040 Write: push addr 0x9 wr data 0x5C -> address 0x9, wr_ni 0, dataW 0x5C stable while rq; rsp_data 0x00.
REQ-041 Back-to-back: push 4 commands with FIFO_DEPTH 4 and no ack -> cmd_ready 0 after the 4th; 5th not accepted; transactions issue in push order; rq low ≥2 cycles between them.
REQ-042 Timeout: no ack -> rq drops after 15 REQ cycles, rsp_valid with rsp_timeout 1, rsp_data 0; a late ack in GAP/IDLE is ignored.
REQ-043 Collision: ack on the edge the counter hits TIMEOUT -> rsp_timeout 0, dataR captured.
REQ-044 Reset mid-REQ with 2 commands queued -> rq 0 immediately, busy 0, no rsp_valid, cmd_ready 1 after release.
